// File: rtl/pc_unit.sv
// Program counter with page/long jumps and a halt/resume/single-step machine.
// Drives the instruction controller and ROM address.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          LOG      = 1'b0
) (
  input  logic        clk,
  input  logic        mr,
  input  logic [7:0]  data_bus,
  input  logic        _pchitmp_in,
  input  logic        _pclo_in,
  input  logic        _pc_in,
  input  logic        _halt_in,
  input  logic        _resume,
  input  logic        _step,
  output logic [15:0] pc,
  output logic [7:0]  pchitmp,
  output logic        halted
);

  localparam int unsigned PC_W = 16;

  typedef enum logic {RUN, HALT} state_t;

  state_t state;

  // Strobes from the decoded instruction are ignored while halted, so the
  // halt instruction can stay on the bus without disturbing pc or pchitmp.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      pc      <= RESET_PC;
      pchitmp <= 8'h00;
      state   <= RUN;
      halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!_pchitmp_in) pchitmp <= data_bus;
          if (!_halt_in) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!_pc_in) begin
            pc <= {pchitmp, data_bus};
          end else if (!_pclo_in) begin
            pc <= {pc[15:8], data_bus};
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        HALT: begin
          if (!_resume) begin
            state  <= RUN;
            halted <= 1'b0;
            pc     <= pc + PC_W'(1);
          end else if (!_step) begin
            pc <= pc + PC_W'(1);
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Simulation trace of jumps and halt transitions; values are pre-edge.
  if (LOG) begin : g_log
    always_ff @(posedge clk) begin
      if (!mr) begin
        if (state == RUN && _halt_in && (!_pc_in || !_pclo_in))
          $write("PC JUMP %h -> %h\n", pc,
                 !_pc_in ? {pchitmp, data_bus} : {pc[15:8], data_bus});
        if (state == RUN && !_halt_in)
          $write("HALT @%h\n", pc);
        if (state == HALT && !_resume)
          $write("RESUME @%h\n", pc);
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected state per edge,
// a monitor pops and compares after each rising edge or async-reset probe.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        mr;
  logic [7:0]  data_bus;
  logic        n_pchitmp, n_pclo, n_pc, n_halt, n_resume, n_step;
  logic [15:0] pc;
  logic [7:0]  pchitmp;
  logic        halted;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  hi;
    logic        halted;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  event chk_ev;

  pc_unit #(.RESET_PC(16'h0000), .LOG(1'b0)) dut (
    .clk         (clk),
    .mr          (mr),
    .data_bus    (data_bus),
    ._pchitmp_in (n_pchitmp),
    ._pclo_in    (n_pclo),
    ._pc_in      (n_pc),
    ._halt_in    (n_halt),
    ._resume     (n_resume),
    ._step       (n_step),
    .pc          (pc),
    .pchitmp     (pchitmp),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge (or per async probe event).
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pchitmp !== e.hi || halted !== e.halted)
          $display("FAIL %s: got pc=%h hi=%h halted=%b, want pc=%h hi=%h halted=%b",
                   e.name, pc, pchitmp, halted, e.pc, e.hi, e.halted);
        else
          passed++;
      end
    end
  end

  task automatic idle();
    n_pchitmp = 1'b1; n_pclo = 1'b1; n_pc = 1'b1;
    n_halt = 1'b1; n_resume = 1'b1; n_step = 1'b1;
  endtask

  // Queue the state expected after the coming rising edge, then advance.
  task automatic cyc(input logic [15:0] p, input logic [7:0] h,
                     input logic hl, input string n);
    q.push_back('{p, h, hl, n});
    @(negedge clk);
  endtask

  // Queue an expectation checked immediately, between edges.
  task automatic probe(input logic [15:0] p, input logic [7:0] h,
                       input logic hl, input string n);
    q.push_back('{p, h, hl, n});
    -> chk_ev;
    #2;
  endtask

  initial begin
    idle();
    mr = 1'b1;
    data_bus = 8'h00;
    @(negedge clk);
    probe(16'h0000, 8'h00, 1'b0, "reset");
    mr = 1'b0;
    for (int i = 1; i <= 5; i++) cyc(16'(i), 8'h00, 1'b0, "incr");

    // Wrap through FFFF
    idle(); n_pchitmp = 1'b0; data_bus = 8'hFF;
    cyc(16'h0006, 8'hFF, 1'b0, "load_hi_ff");
    idle(); n_pc = 1'b0; data_bus = 8'hFE;
    cyc(16'hFFFE, 8'hFF, 1'b0, "long_fffe");
    idle();
    cyc(16'hFFFF, 8'hFF, 1'b0, "wrap_ffff");
    cyc(16'h0000, 8'hFF, 1'b0, "wrap_0000");
    cyc(16'h0001, 8'hFF, 1'b0, "wrap_0001");

    // Page jump and long-over-page priority
    n_pchitmp = 1'b0; data_bus = 8'h12;
    cyc(16'h0002, 8'h12, 1'b0, "load_hi_12");
    idle(); n_pc = 1'b0; data_bus = 8'h34;
    cyc(16'h1234, 8'h12, 1'b0, "long_1234");
    idle(); n_pclo = 1'b0; data_bus = 8'h80;
    cyc(16'h1280, 8'h12, 1'b0, "page_1280");
    idle();
    cyc(16'h1281, 8'h12, 1'b0, "page_incr");
    n_pchitmp = 1'b0; data_bus = 8'hAB;
    cyc(16'h1282, 8'hAB, 1'b0, "load_hi_ab");
    idle(); n_pc = 1'b0; n_pclo = 1'b0; data_bus = 8'hCD;
    cyc(16'hABCD, 8'hAB, 1'b0, "long_beats_page");
    idle();
    cyc(16'hABCE, 8'hAB, 1'b0, "after_long");

    // Staging coincidence: jump uses old pchitmp
    n_pchitmp = 1'b0; data_bus = 8'h11;
    cyc(16'hABCF, 8'h11, 1'b0, "load_hi_11");
    idle(); n_pchitmp = 1'b0; n_pc = 1'b0; data_bus = 8'h22;
    cyc(16'h1122, 8'h22, 1'b0, "stage_coincide");

    // Reach 0040
    idle(); n_pchitmp = 1'b0; data_bus = 8'h00;
    cyc(16'h1123, 8'h00, 1'b0, "load_hi_00");
    idle(); n_pc = 1'b0; data_bus = 8'h3F;
    cyc(16'h003F, 8'h00, 1'b0, "long_003f");
    idle();
    cyc(16'h0040, 8'h00, 1'b0, "incr_0040");

    // Halt; pchitmp load still honoured on the halting edge
    n_halt = 1'b0; n_pchitmp = 1'b0; data_bus = 8'h5A;
    cyc(16'h0040, 8'h5A, 1'b1, "halt_enter");
    // Strobes ignored while halted
    n_pc = 1'b0; n_pclo = 1'b0; data_bus = 8'h77;
    for (int i = 0; i < 3; i++) cyc(16'h0040, 8'h5A, 1'b1, "halt_hold");
    idle(); n_step = 1'b0;
    cyc(16'h0041, 8'h5A, 1'b1, "step");
    idle();
    cyc(16'h0041, 8'h5A, 1'b1, "step_once");
    n_resume = 1'b0; n_step = 1'b0;
    cyc(16'h0042, 8'h5A, 1'b0, "resume_wins");
    idle();
    cyc(16'h0043, 8'h5A, 1'b0, "run_after_resume");
    cyc(16'h0044, 8'h5A, 1'b0, "run_after_resume2");

    // Halt again, then async reset between edges
    n_halt = 1'b0;
    cyc(16'h0044, 8'h5A, 1'b1, "halt_again");
    idle();
    cyc(16'h0044, 8'h5A, 1'b1, "halt_idle");
    #2;
    mr = 1'b1;
    probe(16'h0000, 8'h00, 1'b0, "async_reset");
    @(negedge clk);
    mr = 1'b0;
    cyc(16'h0001, 8'h00, 1'b0, "post_reset1");
    cyc(16'h0002, 8'h00, 1'b0, "post_reset2");

    // Drain the scoreboard with a bound
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
